// File: rtl/pacote_ula.sv
`default_nettype none
// ============================================================================
// Module   : pacote_ula
// Brief    : Shared opcodes, FSM encoding and instruction field layout for
//            the ALU sequencer.
// Revision : 1.0
// ============================================================================
package pacote_ula;

    localparam int LARG_INSTR = 16;
    localparam int LARG_CAMPO = 4;

    localparam int CAMPO_COD_LSB = 12;
    localparam int CAMPO_RD_LSB  = 8;
    localparam int CAMPO_RS_LSB  = 4;
    localparam int CAMPO_RT_LSB  = 0;

    localparam logic [3:0] COD_ADD  = 4'd0;
    localparam logic [3:0] COD_SUB  = 4'd1;
    localparam logic [3:0] COD_AND  = 4'd2;
    localparam logic [3:0] COD_OR   = 4'd3;
    localparam logic [3:0] COD_XOR  = 4'd4;
    localparam logic [3:0] COD_NOT  = 4'd5;
    localparam logic [3:0] COD_SHL  = 4'd6;
    localparam logic [3:0] COD_SHR  = 4'd7;
    localparam logic [3:0] COD_ADDI = 4'd8;
    localparam logic [3:0] COD_ANDI = 4'd9;
    localparam logic [3:0] COD_SUBI = 4'd10;
    localparam logic [3:0] COD_MAX  = COD_SUBI;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DECODIFICA = 2'd1,
        EXECUTA    = 2'd2,
        ESCREVE    = 2'd3
    } estado_t;

    function automatic logic [LARG_CAMPO-1:0] campo(
        input logic [LARG_INSTR-1:0] palavra,
        input int                    lsb
    );
        return palavra[lsb +: LARG_CAMPO];
    endfunction

    function automatic logic codop_legal(input logic [LARG_CAMPO-1:0] codop);
        return codop <= COD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fila_instr.sv
`default_nettype none
// ============================================================================
// Module   : fila_instr
// Brief    : Synchronous instruction FIFO with full/empty flags and occupancy.
// Revision : 1.0
// ============================================================================
module fila_instr #(
    parameter int LARG = 16,
    parameter int PROF = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [LARG-1:0]         i_dado,
    input  logic                    i_pop,
    output logic [LARG-1:0]         o_dado,
    output logic                    o_cheio,
    output logic                    o_vazio,
    output logic [$clog2(PROF):0]   o_nivel
);

    localparam int LARG_END = $clog2(PROF);
    localparam logic [LARG_END:0] c_NIVEL_CHEIO = (LARG_END+1)'(PROF);

    logic [LARG-1:0]   r_mem [PROF];
    logic [LARG_END:0] r_ptr_esc;
    logic [LARG_END:0] r_ptr_lei;
    logic              w_push;
    logic              w_pop;

    // Extra pointer bit distinguishes full from empty; the difference is the level.
    assign o_nivel = r_ptr_esc - r_ptr_lei;
    assign o_cheio = (o_nivel == c_NIVEL_CHEIO);
    assign o_vazio = (o_nivel == '0);
    assign o_dado  = r_mem[r_ptr_lei[LARG_END-1:0]];

    assign w_push = i_push && !o_cheio;
    assign w_pop  = i_pop && !o_vazio;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr_esc <= '0;
            r_ptr_lei <= '0;
        end else begin
            if (w_push) r_ptr_esc <= r_ptr_esc + 1'b1;
            if (w_pop)  r_ptr_lei <= r_ptr_lei + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_ptr_esc[LARG_END-1:0]] <= i_dado;
    end

endmodule
`default_nettype wire

// File: rtl/controle_ula.sv
`default_nettype none
// ============================================================================
// Module   : controle_ula
// Brief    : Multicycle sequencer feeding queued instructions to the ALU and
//            three-port register bank (decode, execute, write-back).
// Revision : 1.0
// ============================================================================
module controle_ula
    import pacote_ula::*;
#(
    parameter int LARG_DADO = 16,
    parameter int PROF_FILA = 4,
    parameter int LARG_CONT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        instr_valido,
    input  logic [15:0]                 instr,
    output logic                        instr_pronto,
    input  logic                        pausa,
    output logic [3:0]                  rf_end1,
    output logic [3:0]                  rf_end2,
    output logic [3:0]                  rf_end3,
    output logic [LARG_DADO-1:0]        rf_dado,
    output logic                        rf_escreve,
    output logic [3:0]                  alu_codop,
    output logic [3:0]                  alu_imediato,
    input  logic [LARG_DADO-1:0]        alu_resultado,
    output logic                        ocupado,
    output logic                        fim,
    output logic                        erro,
    output logic [LARG_CONT-1:0]        contador,
    output logic [$clog2(PROF_FILA):0]  nivel
);

    estado_t                r_estado, w_prox_estado;
    logic [15:0]            r_instr, w_instr;
    logic [3:0]             r_end1, w_end1;
    logic [3:0]             r_end2, w_end2;
    logic [3:0]             r_end3, w_end3;
    logic [3:0]             r_codop, w_codop;
    logic [3:0]             r_imed, w_imed;
    logic [LARG_DADO-1:0]   r_resultado, w_resultado;
    logic [LARG_DADO-1:0]   r_dado, w_dado;
    logic                   r_escreve, w_escreve;
    logic                   r_fim, w_fim;
    logic                   r_erro, w_erro;
    logic [LARG_CONT-1:0]   r_cont, w_cont;

    logic                   w_pop;
    logic                   w_cheio;
    logic                   w_vazio;
    logic [15:0]            w_fila_dado;

    fila_instr #(
        .LARG (16),
        .PROF (PROF_FILA)
    ) u_fila (
        .clk     (clk),
        .reset   (reset),
        .i_push  (instr_valido),
        .i_dado  (instr),
        .i_pop   (w_pop),
        .o_dado  (w_fila_dado),
        .o_cheio (w_cheio),
        .o_vazio (w_vazio),
        .o_nivel (nivel)
    );

    always_comb begin
        w_prox_estado = r_estado;
        w_pop         = 1'b0;
        w_instr       = r_instr;
        w_end1        = r_end1;
        w_end2        = r_end2;
        w_end3        = r_end3;
        w_codop       = r_codop;
        w_imed        = r_imed;
        w_resultado   = r_resultado;
        w_dado        = r_dado;
        w_escreve     = 1'b0;
        w_fim         = 1'b0;
        w_erro        = 1'b0;
        w_cont        = r_cont;
        // While paused nothing advances, so the one-cycle strobes stay low.
        if (!pausa) begin
            case (r_estado)
                OCIOSO: begin
                    if (!w_vazio) begin
                        w_pop         = 1'b1;
                        w_instr       = w_fila_dado;
                        w_prox_estado = DECODIFICA;
                    end
                end
                DECODIFICA: begin
                    w_end1  = campo(r_instr, CAMPO_RS_LSB);
                    w_end2  = campo(r_instr, CAMPO_RT_LSB);
                    w_end3  = campo(r_instr, CAMPO_RD_LSB);
                    w_codop = campo(r_instr, CAMPO_COD_LSB);
                    w_imed  = campo(r_instr, CAMPO_RS_LSB);
                    if (!codop_legal(campo(r_instr, CAMPO_COD_LSB))) begin
                        w_erro        = 1'b1;
                        w_prox_estado = OCIOSO;
                    end else begin
                        w_prox_estado = EXECUTA;
                    end
                end
                EXECUTA: begin
                    w_resultado   = alu_resultado;
                    w_prox_estado = ESCREVE;
                end
                ESCREVE: begin
                    w_dado        = r_resultado;
                    w_escreve     = 1'b1;
                    w_fim         = 1'b1;
                    w_cont        = r_cont + 1'b1;
                    w_prox_estado = OCIOSO;
                end
                default: w_prox_estado = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_instr     <= '0;
            r_end1      <= '0;
            r_end2      <= '0;
            r_end3      <= '0;
            r_codop     <= '0;
            r_imed      <= '0;
            r_resultado <= '0;
            r_dado      <= '0;
            r_escreve   <= 1'b0;
            r_fim       <= 1'b0;
            r_erro      <= 1'b0;
            r_cont      <= '0;
        end else begin
            r_estado    <= w_prox_estado;
            r_instr     <= w_instr;
            r_end1      <= w_end1;
            r_end2      <= w_end2;
            r_end3      <= w_end3;
            r_codop     <= w_codop;
            r_imed      <= w_imed;
            r_resultado <= w_resultado;
            r_dado      <= w_dado;
            r_escreve   <= w_escreve;
            r_fim       <= w_fim;
            r_erro      <= w_erro;
            r_cont      <= w_cont;
        end
    end

    assign instr_pronto = !w_cheio;
    assign ocupado      = (r_estado != OCIOSO) || !w_vazio;
    assign rf_end1      = r_end1;
    assign rf_end2      = r_end2;
    assign rf_end3      = r_end3;
    assign alu_codop    = r_codop;
    assign alu_imediato = r_imed;
    assign rf_dado      = r_dado;
    assign rf_escreve   = r_escreve;
    assign fim          = r_fim;
    assign erro         = r_erro;
    assign contador     = r_cont;

endmodule
`default_nettype wire

// File: tb/tb_controle_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_ula
// Brief    : Directed self-checking bench for the ALU instruction sequencer.
// Revision : 1.0
// ============================================================================
module tb_controle_ula;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valido;
    logic [15:0] instr;
    logic        instr_pronto;
    logic        pausa;
    logic [3:0]  rf_end1, rf_end2, rf_end3;
    logic [15:0] rf_dado;
    logic        rf_escreve;
    logic [3:0]  alu_codop, alu_imediato;
    logic [15:0] alu_resultado;
    logic        ocupado, fim, erro;
    logic [7:0]  contador;
    logic [2:0]  nivel;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_cont = 8'd0;

    controle_ula dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valido  (instr_valido),
        .instr         (instr),
        .instr_pronto  (instr_pronto),
        .pausa         (pausa),
        .rf_end1       (rf_end1),
        .rf_end2       (rf_end2),
        .rf_end3       (rf_end3),
        .rf_dado       (rf_dado),
        .rf_escreve    (rf_escreve),
        .alu_codop     (alu_codop),
        .alu_imediato  (alu_imediato),
        .alu_resultado (alu_resultado),
        .ocupado       (ocupado),
        .fim           (fim),
        .erro          (erro),
        .contador      (contador),
        .nivel         (nivel)
    );

    always #5 clk = ~clk;

    // Fixed register-bank contents seen by the model ALU.
    function automatic logic [15:0] banco(input logic [3:0] r);
        if (r == 4'd1) return 16'h0003;
        if (r == 4'd2) return 16'h0004;
        return 16'h0100 + {12'h000, r};
    endfunction

    always_comb begin
        case (alu_codop)
            4'd0:    alu_resultado = banco(rf_end1) + banco(rf_end2);
            4'd1:    alu_resultado = banco(rf_end1) - banco(rf_end2);
            default: alu_resultado = banco(rf_end1) ^ {12'h000, alu_imediato};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valido = 1'b0; instr = 16'h0000; pausa = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (instr_pronto !== 1'b1 || nivel !== 3'd0 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_fifo: pronto=%b nivel=%0d ocupado=%b, required 1/0/0", instr_pronto, nivel, ocupado);
        end
        n_checks++;
        if ({rf_end1, rf_end2, rf_end3, alu_codop, alu_imediato, rf_dado} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: end=%h/%h/%h cod=%h imed=%h dado=%h, required all zero", rf_end1, rf_end2, rf_end3, alu_codop, alu_imediato, rf_dado);
        end
        n_checks++;
        if ({rf_escreve, fim, erro} !== 3'b000 || contador !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_strobes: esc=%b fim=%b erro=%b cont=%0d, required 0/0/0/0", rf_escreve, fim, erro, contador);
        end
    endtask

    task automatic test_single_add();
        instr = 16'h0312; instr_valido = 1'b1;
        tick();                                   // push edge N
        instr_valido = 1'b0;
        n_checks++;
        if (nivel !== 3'd1 || ocupado !== 1'b1) begin
            n_errors++;
            $display("FAIL add_queued: nivel=%0d ocupado=%b, required 1/1", nivel, ocupado);
        end
        tick();                                   // N+1: popped
        n_checks++;
        if (nivel !== 3'd0) begin
            n_errors++;
            $display("FAIL add_popped: nivel=%0d, required 0", nivel);
        end
        tick();                                   // N+2: decoded
        n_checks++;
        if (rf_end1 !== 4'd1 || rf_end2 !== 4'd2 || rf_end3 !== 4'd3 || alu_codop !== 4'd0 || alu_imediato !== 4'd1) begin
            n_errors++;
            $display("FAIL add_decode: end=%h/%h/%h cod=%h imed=%h, required 1/2/3/0/1", rf_end1, rf_end2, rf_end3, alu_codop, alu_imediato);
        end
        tick();                                   // N+3
        n_checks++;
        if (rf_escreve !== 1'b0) begin
            n_errors++;
            $display("FAIL add_early_write: rf_escreve=%b at N+3, required 0", rf_escreve);
        end
        tick();                                   // N+4
        exp_cont = exp_cont + 8'd1;
        n_checks++;
        if (rf_escreve !== 1'b1 || rf_dado !== 16'h0007 || fim !== 1'b1 || contador !== exp_cont) begin
            n_errors++;
            $display("FAIL add_write: esc=%b dado=%h fim=%b cont=%0d, required 1/0007/1/%0d", rf_escreve, rf_dado, fim, contador, exp_cont);
        end
        tick();                                   // N+5
        n_checks++;
        if (rf_escreve !== 1'b0 || fim !== 1'b0 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL add_after: esc=%b fim=%b ocupado=%b, required 0/0/0", rf_escreve, fim, ocupado);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] palavras [5];
        logic [3:0]  exp_rd   [5];
        logic [15:0] exp_dado [5];
        int k;
        palavras[0] = 16'h0312; exp_rd[0] = 4'd3; exp_dado[0] = 16'h0007;
        palavras[1] = 16'h1421; exp_rd[1] = 4'd4; exp_dado[1] = 16'h0001;
        palavras[2] = 16'h0534; exp_rd[2] = 4'd5; exp_dado[2] = 16'h0207;
        palavras[3] = 16'h1612; exp_rd[3] = 4'd6; exp_dado[3] = 16'hFFFF;
        palavras[4] = 16'h0711; exp_rd[4] = 4'd7; exp_dado[4] = 16'h0006;
        pausa = 1'b1;
        instr_valido = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = palavras[i];
            tick();
        end
        n_checks++;
        if (nivel !== 3'd4 || instr_pronto !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_full: nivel=%0d pronto=%b, required 4/0", nivel, instr_pronto);
        end
        instr = palavras[4];
        tick();
        n_checks++;
        if (nivel !== 3'd4 || rf_escreve !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_ignored: nivel=%0d esc=%b, required 4/0", nivel, rf_escreve);
        end
        pausa = 1'b0;
        k = 0;
        for (int t = 1; t <= 23; t++) begin
            tick();
            if (t == 1) begin
                n_checks++;
                if (nivel !== 3'd3 || instr_pronto !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_space: nivel=%0d pronto=%b, required 3/1", nivel, instr_pronto);
                end
            end
            if (t == 2) begin
                instr_valido = 1'b0;
                n_checks++;
                if (nivel !== 3'd4) begin
                    n_errors++;
                    $display("FAIL b2b_fifth: nivel=%0d, required 4", nivel);
                end
            end
            if (rf_escreve === 1'b1) begin
                exp_cont = exp_cont + 8'd1;
                n_checks++;
                if (k > 4 || t != 4 + 4*k || rf_end3 !== exp_rd[k] || rf_dado !== exp_dado[k] || contador !== exp_cont) begin
                    n_errors++;
                    $display("FAIL b2b_write%0d: t=%0d rd=%h dado=%h cont=%0d, required t=%0d rd=%h dado=%h cont=%0d",
                             k, t, rf_end3, rf_dado, contador, 4 + 4*k, (k < 5) ? exp_rd[k % 5] : 4'h0, (k < 5) ? exp_dado[k % 5] : 16'h0, exp_cont);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 5 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_count: writes=%0d ocupado=%b, required 5/0", k, ocupado);
        end
    endtask

    task automatic test_illegal();
        instr = 16'hB123; instr_valido = 1'b1;
        tick();                                   // N: push illegal
        instr = 16'h1456;
        tick();                                   // N+1: pop illegal, push next
        instr_valido = 1'b0;
        n_checks++;
        if (nivel !== 3'd1) begin
            n_errors++;
            $display("FAIL ill_push_pop: nivel=%0d, required 1", nivel);
        end
        tick();                                   // N+2
        n_checks++;
        if (erro !== 1'b1 || fim !== 1'b0 || rf_escreve !== 1'b0) begin
            n_errors++;
            $display("FAIL ill_erro: erro=%b fim=%b esc=%b, required 1/0/0", erro, fim, rf_escreve);
        end
        begin
            logic viu_esc = 1'b0;
            logic viu_erro = 1'b0;
            for (int i = 0; i < 3; i++) begin      // N+3..N+5
                tick();
                if (rf_escreve === 1'b1) viu_esc = 1'b1;
                if (erro === 1'b1) viu_erro = 1'b1;
            end
            n_checks++;
            if (viu_esc !== 1'b0 || viu_erro !== 1'b0) begin
                n_errors++;
                $display("FAIL ill_quiet: esc_seen=%b erro_seen=%b, required 0/0", viu_esc, viu_erro);
            end
        end
        tick();                                   // N+6
        exp_cont = exp_cont + 8'd1;
        n_checks++;
        if (rf_escreve !== 1'b1 || rf_end3 !== 4'd4 || rf_dado !== 16'hFFFF || contador !== exp_cont) begin
            n_errors++;
            $display("FAIL ill_next: esc=%b rd=%h dado=%h cont=%0d, required 1/4/FFFF/%0d", rf_escreve, rf_end3, rf_dado, contador, exp_cont);
        end
        tick();
    endtask

    task automatic test_pausa_escreve();
        instr = 16'h0534; instr_valido = 1'b1;
        tick();                                   // N
        instr_valido = 1'b0;
        tick(); tick(); tick();                   // N+3: in ESCREVE
        pausa = 1'b1;
        begin
            logic viu = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (rf_escreve === 1'b1 || fim === 1'b1) viu = 1'b1;
            end
            n_checks++;
            if (viu !== 1'b0 || rf_end3 !== 4'd5 || contador !== exp_cont) begin
                n_errors++;
                $display("FAIL pausa_hold: strobe_seen=%b rd=%h cont=%0d, required 0/5/%0d", viu, rf_end3, contador, exp_cont);
            end
        end
        pausa = 1'b0;
        tick();
        exp_cont = exp_cont + 8'd1;
        n_checks++;
        if (rf_escreve !== 1'b1 || rf_dado !== 16'h0207 || contador !== exp_cont) begin
            n_errors++;
            $display("FAIL pausa_release: esc=%b dado=%h cont=%0d, required 1/0207/%0d", rf_escreve, rf_dado, contador, exp_cont);
        end
        tick();
        n_checks++;
        if (rf_escreve !== 1'b0 || contador !== exp_cont) begin
            n_errors++;
            $display("FAIL pausa_once: esc=%b cont=%0d, required 0/%0d", rf_escreve, contador, exp_cont);
        end
    endtask

    task automatic test_reset_mid();
        instr = 16'h0312; instr_valido = 1'b1;
        tick();                                   // N
        instr = 16'h0413;
        tick();                                   // N+1
        instr = 16'h0514;
        tick();                                   // N+2: EXECUTA
        instr_valido = 1'b0;
        n_checks++;
        if (rf_end3 !== 4'd3 || nivel !== 3'd2) begin
            n_errors++;
            $display("FAIL rmid_setup: rd=%h nivel=%0d, required 3/2", rf_end3, nivel);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (nivel !== 3'd0 || instr_pronto !== 1'b1 || ocupado !== 1'b0 || contador !== 8'd0 || rf_end3 !== 4'd0) begin
            n_errors++;
            $display("FAIL rmid_async: nivel=%0d pronto=%b ocupado=%b cont=%0d rd=%h, required 0/1/0/0/0", nivel, instr_pronto, ocupado, contador, rf_end3);
        end
        tick(); tick();
        reset = 1'b0;
        exp_cont = 8'd0;
        begin
            logic viu = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (rf_escreve === 1'b1 || fim === 1'b1) viu = 1'b1;
            end
            n_checks++;
            if (viu !== 1'b0 || nivel !== 3'd0 || ocupado !== 1'b0 || contador !== 8'd0) begin
                n_errors++;
                $display("FAIL rmid_after: write_seen=%b nivel=%0d ocupado=%b cont=%0d, required 0/0/0/0", viu, nivel, ocupado, contador);
            end
        end
    endtask

    task automatic test_wrap();
        int pushes = 0;
        int fims   = 0;
        int cyc    = 0;
        logic vai;
        pausa = 1'b1;
        instr = 16'h0312; instr_valido = 1'b1;
        tick(); tick();
        pushes = 2;
        n_checks++;
        if (nivel !== 3'd2) begin
            n_errors++;
            $display("FAIL wrap_level2: nivel=%0d, required 2", nivel);
        end
        pausa = 1'b0;
        tick();                                   // push and pop together
        pushes = 3;
        n_checks++;
        if (nivel !== 3'd2) begin
            n_errors++;
            $display("FAIL wrap_push_pop: nivel=%0d, required 2", nivel);
        end
        while (fims < 256 && cyc < 2000) begin
            if (pushes >= 256) instr_valido = 1'b0;
            vai = instr_valido && instr_pronto;
            tick();
            cyc++;
            if (vai) pushes++;
            if (fim === 1'b1) begin
                fims++;
                if (fims == 255) begin
                    n_checks++;
                    if (contador !== 8'hFF) begin
                        n_errors++;
                        $display("FAIL wrap_255: cont=%0d, required 255", contador);
                    end
                end
            end
        end
        n_checks++;
        if (fims != 256 || contador !== 8'd0) begin
            n_errors++;
            $display("FAIL wrap_zero: retired=%0d cont=%0d, required 256/0", fims, contador);
        end
        tick(); tick();
        n_checks++;
        if (ocupado !== 1'b0 || nivel !== 3'd0 || pushes != 256) begin
            n_errors++;
            $display("FAIL wrap_drain: ocupado=%b nivel=%0d pushes=%0d, required 0/0/256", ocupado, nivel, pushes);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_illegal();
        test_pausa_escreve();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
